// File: rtl/online_otf_convert_pkg.sv
// rtl/online_otf_convert_pkg.sv - shared online-arithmetic digit codes and FSM state encodings
package online_otf_convert_pkg;

    localparam int PLUS_BIT  = 1;
    localparam int MINUS_BIT = 0;

    localparam logic [1:0] DIGIT_ZERO = 2'b00;
    localparam logic [1:0] DIGIT_NEG  = 2'b01;
    localparam logic [1:0] DIGIT_POS  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } otf_state_e;

endpackage

// File: rtl/online_otf_step.sv
// rtl/online_otf_step.sv - one combinational on-the-fly conversion digit step
module online_otf_step
    import online_otf_convert_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] qm,
    input  logic [1:0]   digit,
    output logic [W-1:0] q_next,
    output logic [W-1:0] qm_next
);

    // Code 11 falls into the default arm and behaves exactly like a zero digit.
    always_comb begin
        q_next  = {q[W-2:0], 1'b0};
        qm_next = {qm[W-2:0], 1'b1};
        case (digit)
            DIGIT_POS: begin
                q_next  = {q[W-2:0], 1'b1};
                qm_next = {q[W-2:0], 1'b0};
            end
            DIGIT_NEG: begin
                q_next  = {qm[W-2:0], 1'b1};
                qm_next = {qm[W-2:0], 1'b0};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/online_otf_convert.sv
// rtl/online_otf_convert.sv - serial MSD-first redundant-to-two's-complement converter
module online_otf_convert
    import online_otf_convert_pkg::*;
#(
    parameter int  Stage = 4,
    localparam int ND    = Stage + 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*ND-1:0] y,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [ND:0]     z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int             CNT_W    = $clog2(ND);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ND - 1);

    otf_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*ND-1:0]   sr_q, sr_d;
    logic [ND:0]       q_q, q_d;
    logic [ND:0]       qm_q, qm_d;
    logic [ND:0]       z_q, z_d;
    logic [ND:0]       q_step, qm_step;

    online_otf_step #(.W(ND + 1)) u_step (
        .q       (q_q),
        .qm      (qm_q),
        .digit   (sr_q[2*ND-1 -: 2]),
        .q_next  (q_step),
        .qm_next (qm_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        q_d     = q_q;
        qm_d    = qm_q;
        z_d     = z_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CONV;
                    sr_d    = y;
                    q_d     = '0;
                    qm_d    = '1;
                    cnt_d   = '0;
                end
            end
            ST_CONV: begin
                q_d  = q_step;
                qm_d = qm_step;
                sr_d = {sr_q[2*ND-3:0], 2'b00};
                // The last step publishes straight into z so out_valid and z rise together.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    z_d     = q_step;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            q_q     <= '0;
            qm_q    <= '1;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            z_q     <= z_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_CONV);
    assign z         = z_q;

endmodule

// File: tb/tb_online_otf_convert.sv
// tb/tb_online_otf_convert.sv - self-checking bench for online_otf_convert
module tb_online_otf_convert;

    localparam int ND = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*ND-1:0] y;
    logic            in_valid;
    logic            in_ready;
    logic [ND:0]     z;
    logic            out_valid;
    logic            out_ready;
    logic            busy;

    int errors = 0;
    int checks = 0;

    online_otf_convert #(.Stage(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer sum of signed digits times powers of two.
    function automatic logic [ND:0] ref_val(input logic [2*ND-1:0] w);
        int s = 0;
        for (int i = 0; i < ND; i++) begin
            if (w[2*i+1] && !w[2*i])
                s += (1 << i);
            else if (w[2*i] && !w[2*i+1])
                s -= (1 << i);
        end
        return s[ND:0];
    endfunction

    // Offers one word and waits for out_valid; reports z, latency and in_ready activity.
    task automatic run_word(input logic [2*ND-1:0] w, output logic [ND:0] zo,
                            output int lat, output int rdy_hi, output bit to);
        int n = 0;
        to     = 1'b0;
        rdy_hi = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) to = 1'b1;
        y        = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        y        = 18'($urandom);
        lat      = 0;
        if (in_ready) rdy_hi++;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
            if (in_ready) rdy_hi++;
        end
        if (!out_valid) to = 1'b1;
        zo = z;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y         = '0;
        tick();
        checks++;
        if (z !== 10'h000) begin
            errors++;
            $display("FAIL reset_z: got %h want 000", z);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_zero();
        logic [ND:0] zo;
        int lat, rdy_hi;
        bit to;
        out_ready = 1'b1;
        run_word('0, zo, lat, rdy_hi, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL zero_timeout: got timeout want completion");
        end
        checks++;
        if (zo !== 10'h000) begin
            errors++;
            $display("FAIL zero_z: got %h want 000", zo);
        end
        checks++;
        if (lat !== ND) begin
            errors++;
            $display("FAIL zero_latency: got %0d want %0d", lat, ND);
        end
        checks++;
        if (rdy_hi !== 0) begin
            errors++;
            $display("FAIL zero_in_ready_window: in_ready high %0d cycles want 0", rdy_hi);
        end
        tick();
    endtask

    task automatic test_directed();
        logic [2*ND-1:0] words [3];
        logic [ND:0]     want  [3];
        logic [ND:0]     zo;
        int lat, rdy_hi;
        bit to;
        words[0] = 18'h20000; want[0] = 10'd256;
        words[1] = 18'h24000; want[1] = 10'd128;
        words[2] = 18'h15555; want[2] = 10'h201;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_word(words[k], zo, lat, rdy_hi, to);
            checks++;
            if (to || zo !== want[k]) begin
                errors++;
                $display("FAIL directed_%0d: got %h (timeout=%0d) want %h", k, zo, to, want[k]);
            end
            tick();
        end
    endtask

    task automatic test_alt_and_11();
        logic [2*ND-1:0] w;
        logic [ND:0]     zo;
        int lat, rdy_hi;
        bit to;
        out_ready = 1'b1;
        w = 18'h26666;
        run_word(w, zo, lat, rdy_hi, to);
        checks++;
        if (to || zo !== 10'd171) begin
            errors++;
            $display("FAIL alternating: got %h want %h", zo, 10'd171);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            w = 18'($urandom);
            w[2*(k % ND) +: 2]       = 2'b11;
            w[2*((k + 4) % ND) +: 2] = 2'b11;
            run_word(w, zo, lat, rdy_hi, to);
            checks++;
            if (to || zo !== ref_val(w)) begin
                errors++;
                $display("FAIL code11_%0d: y=%h got %h want %h", k, w, zo, ref_val(w));
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [2*ND-1:0] w, w2;
        logic [ND:0]     zo, want;
        int lat, rdy_hi;
        bit to;
        out_ready = 1'b0;
        w    = 18'h2a5a1;
        want = ref_val(w);
        run_word(w, zo, lat, rdy_hi, to);
        checks++;
        if (to || zo !== want) begin
            errors++;
            $display("FAIL hold_first: got %h want %h", zo, want);
        end
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            y        = 18'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || z !== want || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: out_valid=%b z=%h in_ready=%b want 1 %h 0",
                         c, out_valid, z, in_ready, want);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== want) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b z=%h want 1 0 %h",
                     in_ready, out_valid, z, want);
        end
        w2 = 18'h1a6a9;
        out_ready = 1'b1;
        run_word(w2, zo, lat, rdy_hi, to);
        checks++;
        if (to || zo !== ref_val(w2)) begin
            errors++;
            $display("FAIL hold_next_word: got %h want %h", zo, ref_val(w2));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [2*ND-1:0] w;
        logic [ND:0]     zo;
        int lat, rdy_hi;
        bit to;
        out_ready = 1'b1;
        y         = 18'h15555;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || z !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b out_valid=%b z=%h want 0 0 000",
                     busy, out_valid, z);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 10'h000) begin
            errors++;
            $display("FAIL reset_mid_idle: in_ready=%b out_valid=%b z=%h want 1 0 000",
                     in_ready, out_valid, z);
        end
        w = 18'h29a46;
        run_word(w, zo, lat, rdy_hi, to);
        checks++;
        if (to || zo !== ref_val(w) || lat !== ND) begin
            errors++;
            $display("FAIL reset_mid_recover: got %h lat %0d want %h lat %0d", zo, lat, ref_val(w), ND);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [ND:0]     exp_q [$];
        logic [2*ND-1:0] w;
        logic [ND:0]     want;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int last = -1;
        out_ready = 1'b1;
        while (got < 1000 && cyc < 20000) begin
            if (in_ready) begin
                if (sent < 1000) begin
                    w        = 18'($urandom);
                    y        = w;
                    in_valid = 1'b1;
                    exp_q.push_back(ref_val(w));
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            cyc++;
            if (out_valid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (z !== want) begin
                    errors++;
                    $display("FAIL b2b_z_%0d: got %h want %h", got, z, want);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== ND + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: got %0d want %0d", got, cyc - last, ND + 2);
                    end
                end
                last = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 1000) begin
            errors++;
            $display("FAIL b2b_count: got %0d words want 1000", got);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_directed();
        test_alt_and_11();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
